// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - icache geometry constants and FSM state encoding
package icache_pkg;

   localparam int ICACHE_INDEX_WIDTH = 6;
   localparam int ADDR_WIDTH         = 18;
   localparam int ICACHE_TAG_WIDTH   = ADDR_WIDTH - ICACHE_INDEX_WIDTH - 2;
   localparam int ICACHE_LINES       = 1 << ICACHE_INDEX_WIDTH;

   typedef enum logic {
      ICACHE_IDLE = 1'b0,
      ICACHE_MISS = 1'b1
   } icache_state_e;

endpackage

// File: rtl/icache_if.sv
// rtl/icache_if.sv - word fetch request/response bus (decoder side and memctrl side)
interface icache_if;

   logic        enable;
   logic [31:0] addr;
   logic        ready;
   logic [31:0] data;

   modport master (
      output enable,
      output addr,
      input  ready,
      input  data
   );

   modport slave (
      input  enable,
      input  addr,
      output ready,
      output data
   );

endinterface

// File: rtl/icache_array.sv
// rtl/icache_array.sv - direct-mapped valid/tag/data storage, async read, sync write
module icache_array
   import icache_pkg::*;
(
   input  logic                          clk_in,
   input  logic                          rst_in,
   input  logic [ICACHE_INDEX_WIDTH-1:0] rd_index,
   output logic                          rd_valid,
   output logic [ICACHE_TAG_WIDTH-1:0]   rd_tag,
   output logic [31:0]                   rd_data,
   input  logic                          wr_en,
   input  logic [ICACHE_INDEX_WIDTH-1:0] wr_index,
   input  logic [ICACHE_TAG_WIDTH-1:0]   wr_tag,
   input  logic [31:0]                   wr_data
);

   logic [ICACHE_LINES-1:0]     valid;
   logic [ICACHE_TAG_WIDTH-1:0] tag_mem  [ICACHE_LINES];
   logic [31:0]                 data_mem [ICACHE_LINES];

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         valid <= '0;
      end else if (wr_en) begin
         valid[wr_index] <= 1'b1;
      end
   end

   // Tag and data are left unreset; the valid bit alone guards them.
   always_ff @(posedge clk_in) begin
      if (!rst_in && wr_en) begin
         tag_mem[wr_index]  <= wr_tag;
         data_mem[wr_index] <= wr_data;
      end
   end

   assign rd_valid = valid[rd_index];
   assign rd_tag   = tag_mem[rd_index];
   assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped instruction cache between decoder fetch and memctrl
module icache
   import icache_pkg::*;
(
   input  logic     clk_in,
   input  logic     rst_in,
   input  logic     rdy_in,
   input  logic     clear,
   icache_if.slave  fetch,
   icache_if.master mem
);

   icache_state_e state_q, state_d;
   logic          if_ready_q, if_ready_d;
   logic [31:0]   inst_q, inst_d;
   logic          mem_en_q, mem_en_d;
   logic [31:0]   mem_addr_q, mem_addr_d;

   logic                        rd_valid;
   logic [ICACHE_TAG_WIDTH-1:0] rd_tag;
   logic [31:0]                 rd_data;
   logic                        wr_en;
   logic                        hit;
   logic                        accept;

   icache_array u_array (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .rd_index (fetch.addr[ICACHE_INDEX_WIDTH+1:2]),
      .rd_valid (rd_valid),
      .rd_tag   (rd_tag),
      .rd_data  (rd_data),
      .wr_en    (wr_en),
      .wr_index (mem_addr_q[ICACHE_INDEX_WIDTH+1:2]),
      .wr_tag   (mem_addr_q[ADDR_WIDTH-1:ICACHE_INDEX_WIDTH+2]),
      .wr_data  (mem.data)
   );

   assign hit = rd_valid && (rd_tag == fetch.addr[ADDR_WIDTH-1:ICACHE_INDEX_WIDTH+2]);

   // Blocking acceptance while if_ready is high forces a bubble so a held request cannot double-fetch.
   assign accept = (state_q == ICACHE_IDLE) && fetch.enable && !if_ready_q && !clear;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q    <= ICACHE_IDLE;
         if_ready_q <= 1'b0;
         inst_q     <= '0;
         mem_en_q   <= 1'b0;
         mem_addr_q <= '0;
      end else if (rdy_in) begin
         state_q    <= state_d;
         if_ready_q <= if_ready_d;
         inst_q     <= inst_d;
         mem_en_q   <= mem_en_d;
         mem_addr_q <= mem_addr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ICACHE_IDLE: begin
            if (accept && !hit) begin
               state_d = ICACHE_MISS;
            end
         end
         ICACHE_MISS: begin
            if (clear || mem.ready) begin
               state_d = ICACHE_IDLE;
            end
         end
         default: state_d = ICACHE_IDLE;
      endcase
   end

   // The miss address register doubles as the latched fill index/tag.
   always_comb begin
      if_ready_d = 1'b0;
      inst_d     = inst_q;
      mem_en_d   = mem_en_q;
      mem_addr_d = mem_addr_q;
      wr_en      = 1'b0;
      case (state_q)
         ICACHE_IDLE: begin
            mem_en_d = 1'b0;
            if (accept) begin
               if (hit) begin
                  if_ready_d = 1'b1;
                  inst_d     = rd_data;
               end else begin
                  mem_en_d   = 1'b1;
                  mem_addr_d = fetch.addr & ~32'h3;
               end
            end
         end
         ICACHE_MISS: begin
            if (clear) begin
               mem_en_d = 1'b0;
            end else if (mem.ready) begin
               wr_en      = rdy_in;
               if_ready_d = 1'b1;
               inst_d     = mem.data;
               mem_en_d   = 1'b0;
            end
         end
         default: mem_en_d = 1'b0;
      endcase
   end

   assign fetch.ready = if_ready_q;
   assign fetch.data  = inst_q;
   assign mem.enable  = mem_en_q;
   assign mem.addr    = mem_addr_q;

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - self-checking bench for icache: vector table, corner sequences, random fetches
module tb_icache;

   logic clk_in = 1'b0;
   logic rst_in;
   logic rdy_in;
   logic clear;

   icache_if fetch_bus ();
   icache_if mem_bus ();

   icache dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .rdy_in (rdy_in),
      .clear  (clear),
      .fetch  (fetch_bus),
      .mem    (mem_bus)
   );

   always #5 clk_in = ~clk_in;

   int total = 0;
   int bad   = 0;

   // Reference model: what each of the 64 lines currently holds.
   bit          m_valid [64];
   int unsigned m_tag   [64];
   logic [31:0] m_data  [64];

   typedef struct {
      logic [31:0] addr;
      int          lat;
      logic [31:0] word;
      logic        exp_hit;
      logic [31:0] exp_inst;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %08h want %08h", name, act, exp);
      end
   endtask

   function automatic int unsigned idx_of(input logic [31:0] a);
      return (a >> 2) % 64;
   endfunction

   function automatic int unsigned tag_of(input logic [31:0] a);
      return (a >> 8) % 1024;
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
   endfunction

   function automatic logic model_hit(input logic [31:0] a);
      return m_valid[idx_of(a)] && (m_tag[idx_of(a)] == tag_of(a));
   endfunction

   task automatic model_fill(input logic [31:0] a, input logic [31:0] w);
      m_valid[idx_of(a)] = 1'b1;
      m_tag[idx_of(a)]   = tag_of(a);
      m_data[idx_of(a)]  = w;
   endtask

   // Called at a negedge with the cache idle; returns at a negedge after the bubble cycle.
   task automatic fetch(input logic [31:0] addr, input int lat, input logic [31:0] word,
                        output logic hit, output logic [31:0] got);
      logic [31:0] aligned;
      aligned = addr & ~32'h3;
      fetch_bus.enable = 1'b1;
      fetch_bus.addr   = addr;
      @(posedge clk_in);
      @(negedge clk_in);
      fetch_bus.enable = 1'b0;
      hit = fetch_bus.ready;
      got = fetch_bus.data;
      if (hit) begin
         check("hit_no_mem_req", {31'b0, mem_bus.enable}, 32'd0);
      end else begin
         check("miss_req", {31'b0, mem_bus.enable}, 32'd1);
         check("miss_addr", mem_bus.addr, aligned);
         for (int i = 1; i < lat; i++) begin
            fetch_bus.addr = $urandom;
            @(posedge clk_in);
            @(negedge clk_in);
            check("miss_hold", {30'b0, mem_bus.enable, fetch_bus.ready}, 32'd2);
            check("miss_hold_addr", mem_bus.addr, aligned);
         end
         mem_bus.ready = 1'b1;
         mem_bus.data  = word;
         @(posedge clk_in);
         @(negedge clk_in);
         mem_bus.ready = 1'b0;
         mem_bus.data  = $urandom;
         check("fill_ready", {31'b0, fetch_bus.ready}, 32'd1);
         check("fill_mem_drop", {31'b0, mem_bus.enable}, 32'd0);
         got = fetch_bus.data;
      end
      @(posedge clk_in);
      @(negedge clk_in);
      check("ready_pulse_end", {31'b0, fetch_bus.ready}, 32'd0);
   endtask

   task automatic run_fetch(input string name, input logic [31:0] addr, input int lat,
                            input logic [31:0] word, input logic exp_hit, input logic [31:0] exp_inst);
      logic        hit;
      logic [31:0] got;
      fetch(addr, lat, word, hit, got);
      check({name, "_hit"}, {31'b0, hit}, {31'b0, exp_hit});
      check({name, "_inst"}, got, exp_inst);
      if (!exp_hit) model_fill(addr, word);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      logic [31:0] w;
      logic        eh;
      int unsigned ix, tg;

      vecs[0] = '{32'h0000_0000, 4, 32'h0000_0013, 1'b0, 32'h0000_0013};
      vecs[1] = '{32'h0000_0000, 1, 32'hFFFF_FFFF, 1'b1, 32'h0000_0013};
      vecs[2] = '{32'h0000_0004, 2, 32'hAAAA_0001, 1'b0, 32'hAAAA_0001};
      vecs[3] = '{32'h0000_0104, 3, 32'hBBBB_0002, 1'b0, 32'hBBBB_0002};
      vecs[4] = '{32'h0000_0006, 1, 32'hAAAA_0001, 1'b0, 32'hAAAA_0001};
      vecs[5] = '{32'h0000_0104, 5, 32'hBBBB_0002, 1'b0, 32'hBBBB_0002};
      vecs[6] = '{32'h0000_0003, 1, 32'hFFFF_FFFF, 1'b1, 32'h0000_0013};

      for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;

      // Reset while rdy_in is low: reset must still win.
      rst_in = 1'b1;
      rdy_in = 1'b0;
      clear  = 1'b0;
      fetch_bus.enable = 1'b0;
      fetch_bus.addr   = '0;
      mem_bus.ready    = 1'b0;
      mem_bus.data     = '0;
      repeat (2) @(posedge clk_in);
      @(negedge clk_in);
      check("rst_if_ready", {31'b0, fetch_bus.ready}, 32'd0);
      check("rst_inst", fetch_bus.data, 32'd0);
      check("rst_mem_en", {31'b0, mem_bus.enable}, 32'd0);
      check("rst_mem_addr", mem_bus.addr, 32'd0);
      rst_in = 1'b0;
      rdy_in = 1'b1;
      @(posedge clk_in);
      @(negedge clk_in);

      for (int i = 0; i < 7; i++) begin
         run_fetch($sformatf("vec%0d", i), vecs[i].addr, vecs[i].lat, vecs[i].word,
                   vecs[i].exp_hit, vecs[i].exp_inst);
      end

      // Held request on a cached line alternates 0,1,0,1,0,1.
      check("held_0", {31'b0, fetch_bus.ready}, 32'd0);
      fetch_bus.enable = 1'b1;
      fetch_bus.addr   = 32'h0000_0000;
      for (int k = 1; k < 6; k++) begin
         @(posedge clk_in);
         @(negedge clk_in);
         check($sformatf("held_%0d", k), {31'b0, fetch_bus.ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
         check("held_no_mem", {31'b0, mem_bus.enable}, 32'd0);
         if (k % 2 == 1) check("held_inst", fetch_bus.data, 32'h0000_0013);
      end
      fetch_bus.enable = 1'b0;
      @(posedge clk_in);
      @(negedge clk_in);

      // A request coinciding with clear is not accepted.
      fetch_bus.enable = 1'b1;
      fetch_bus.addr   = 32'h0000_0000;
      clear = 1'b1;
      @(posedge clk_in);
      @(negedge clk_in);
      clear = 1'b0;
      fetch_bus.enable = 1'b0;
      check("clr_idle_ready", {31'b0, fetch_bus.ready}, 32'd0);
      check("clr_idle_mem", {31'b0, mem_bus.enable}, 32'd0);

      // Clear together with mem ready drops the fill.
      fetch_bus.enable = 1'b1;
      fetch_bus.addr   = 32'h0000_0200;
      @(posedge clk_in);
      @(negedge clk_in);
      fetch_bus.enable = 1'b0;
      check("clrmiss_req", {31'b0, mem_bus.enable}, 32'd1);
      check("clrmiss_addr", mem_bus.addr, 32'h0000_0200);
      @(posedge clk_in);
      @(negedge clk_in);
      clear = 1'b1;
      mem_bus.ready = 1'b1;
      mem_bus.data  = 32'h1234_5678;
      @(posedge clk_in);
      @(negedge clk_in);
      clear = 1'b0;
      mem_bus.ready = 1'b0;
      check("clrmiss_no_ready", {31'b0, fetch_bus.ready}, 32'd0);
      check("clrmiss_mem_drop", {31'b0, mem_bus.enable}, 32'd0);
      @(posedge clk_in);
      @(negedge clk_in);
      check("clrmiss_still_quiet", {30'b0, mem_bus.enable, fetch_bus.ready}, 32'd0);
      run_fetch("clrmiss_refetch", 32'h0000_0200, 2, 32'hCAFE_0200, 1'b0, 32'hCAFE_0200);

      // rdy_in low during a miss freezes everything, including a mem ready pulse.
      fetch_bus.enable = 1'b1;
      fetch_bus.addr   = 32'h0000_0308;
      @(posedge clk_in);
      @(negedge clk_in);
      fetch_bus.enable = 1'b0;
      check("stall_req", {31'b0, mem_bus.enable}, 32'd1);
      rdy_in = 1'b0;
      mem_bus.ready = 1'b1;
      mem_bus.data  = 32'hDEAD_0308;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk_in);
         @(negedge clk_in);
         mem_bus.ready = 1'b0;
         check("stall_hold", {30'b0, mem_bus.enable, fetch_bus.ready}, 32'd2);
         check("stall_addr", mem_bus.addr, 32'h0000_0308);
         check("stall_inst", fetch_bus.data, 32'hCAFE_0200);
      end
      rdy_in = 1'b1;
      @(posedge clk_in);
      @(negedge clk_in);
      check("stall_no_fill", {30'b0, mem_bus.enable, fetch_bus.ready}, 32'd2);
      mem_bus.ready = 1'b1;
      mem_bus.data  = 32'h0BAD_0308;
      @(posedge clk_in);
      @(negedge clk_in);
      mem_bus.ready = 1'b0;
      check("stall_fill_ready", {31'b0, fetch_bus.ready}, 32'd1);
      check("stall_fill_inst", fetch_bus.data, 32'h0BAD_0308);
      check("stall_fill_mem", {31'b0, mem_bus.enable}, 32'd0);
      model_fill(32'h0000_0308, 32'h0BAD_0308);
      @(posedge clk_in);
      @(negedge clk_in);
      run_fetch("stall_rehit", 32'h0000_0308, 1, 32'hFFFF_FFFF, 1'b1, 32'h0BAD_0308);

      // Random fetches on a few conflicting lines, checked against the line model.
      for (int n = 0; n < 60; n++) begin
         ix = $urandom_range(0, 3);
         tg = $urandom_range(0, 3);
         if (tg == 3) tg = 1023;
         a  = (tg << 8) | (ix << 2) | $urandom_range(0, 3);
         eh = model_hit(a);
         w  = mem_word(a & ~32'h3);
         run_fetch($sformatf("rnd%0d", n), a, $urandom_range(1, 5), w, eh,
                   eh ? m_data[idx_of(a)] : w);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped instruction cache between the decoder's fetch port and memctrl's instruction-fetch port.
- Hits return an instruction word one cycle after the request is accepted, with no memctrl traffic.
- Misses forward a single word fetch to memctrl, fill the line, then return the word.
- Entries are never invalidated after reset; instruction memory is read-only to the core.

Parameters:
- INDEX_WIDTH, 6, log2 of line count (64 lines, one 32-bit word per line)
- ADDR_WIDTH, 18, physical address bits used (0x00000-0x3FFFF)

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous, active-high reset
- rdy_in  input  1  global enable; when low, all state and outputs freeze
- clear  input  1  pipeline flush from ROB misprediction, synchronous
- if_enable  input  1  decoder fetch request, level
- if_addr  input  32  fetch address; bits [1:0] ignored
- if_ready  output  1  one-cycle pulse: inst is valid
- inst  output  32  fetched instruction
- mem_if_enable  output  1  request to memctrl, held until mem_if_ready
- mem_if_addr  output  32  word-aligned miss address to memctrl
- mem_if_ready  input  1  memctrl fetch complete, one-cycle pulse
- mem_inst  input  32  word from memctrl, valid with mem_if_ready

Behaviour:
- Address split:
  - index = if_addr[INDEX_WIDTH+1:2]
  - tag = if_addr[ADDR_WIDTH-1:INDEX_WIDTH+2]
  - hit = valid[index] && tag_array[index]==tag
- Reset (rst_in=1 at posedge):
  - all valid bits 0; state IDLE
  - if_ready=0, inst=0, mem_if_enable=0, mem_if_addr=0
  - tag and data arrays are not reset
- rdy_in=0: no state, array or output register changes; rst_in takes priority over rdy_in.
- States: IDLE, MISS.
- IDLE:
  - A request is accepted when if_enable=1 && if_ready==0 && clear==0. The cycle while if_ready is high never accepts, which gives one mandatory bubble so a held if_enable cannot double-fetch.
  - Hit: next cycle if_ready=1, inst=data_array[index]; stay IDLE. Latency is 1 cycle.
  - Miss: latch the address; next cycle state=MISS, mem_if_enable=1, mem_if_addr={addr[31:2],2'b00}.
- MISS:
  - mem_if_enable and mem_if_addr are held stable until mem_if_ready=1.
  - On mem_if_ready=1 && clear==0:
    - write valid=1, tag and data at the latched index
    - next cycle: if_ready=1, inst=mem_inst, mem_if_enable=0, state=IDLE
  - Miss latency = memctrl latency + 1.
- clear=1 (any state, rdy_in=1):
  - next cycle: state=IDLE, mem_if_enable=0, if_ready=0
  - any pending fill is dropped, including a mem_if_ready arriving in the same cycle (clear wins)
  - valid, tag and data arrays are preserved
  - no request is accepted in the clear cycle
- if_ready is never high for two consecutive cycles.
- if_ready is only high in the cycle directly after an accepted hit or a completed fill.
- Index wrap: addresses differing only in tag bits evict each other. Last fill wins; there is no replacement state.
- if_addr changing while in MISS is ignored; the latched address is served.

Decomposition:
- Shared defines header, alongside the existing ROB_WIDTH macros:
  - ICACHE_INDEX_WIDTH
  - state encodings ICACHE_IDLE / ICACHE_MISS
  - ADDR_WIDTH
- One natural sub-module, icache_array:
  - valid/tag/data storage
  - combinational read by index, synchronous write port
  - synchronous valid clear on rst_in
- The FSM and handshake logic stay in icache.

Test Plan:
- Cold miss: reset, if_enable=1, if_addr=0x0000. Required: mem_if_enable=1 with mem_if_addr=0x0 one cycle later. Memctrl model returns 0x00000013 after 4 cycles. Required: if_ready pulses once with inst=0x00000013; mem_if_enable drops the same cycle.
- Hit after fill: re-request 0x0000. Required: if_ready=1, inst=0x00000013 exactly 1 cycle after acceptance; mem_if_enable stays 0 throughout.
- Conflict eviction: fill 0x0004 with 0xAAAA0001, then 0x0104 (same index, INDEX_WIDTH=6) with 0xBBBB0002, then request 0x0004. Required: miss; memctrl is re-requested with mem_if_addr=0x0004.
- Clear mid-miss: miss on 0x0200, assert clear together with mem_if_ready (mem_inst=0x12345678). Required: no if_ready, state IDLE, mem_if_enable=0; a later 0x0200 request misses again.
- rdy_in stall: during MISS drive rdy_in=0 for 3 cycles with mem_if_ready=1 pulsed. Required: no fill and outputs unchanged. Memctrl re-pulses after rdy_in=1; required: normal completion with the correct inst.
- Held if_enable: keep if_enable=1, addr=0x0000 (cached) for 6 cycles. Required: if_ready pattern 0,1,0,1,0,1 (alternating, never consecutive).
